// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg: shared register-file constants used by the write-back path.
//   REG_ADDR_W  register address width
//   REG_DATA_W  register data width
//   REG_ZERO    hardwired-zero register index
//   multiValid  true when two or more request bits are set
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Requester vectors are zero-extended to 8 bits, the widest supported NUM_REQ.
  function automatic logic multiValid(input logic [7:0] reqVec);
    return $countones(reqVec) > 1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a rotating priority pointer.
//   clock       rising-edge clock
//   ctrl_reset  asynchronous active-high reset; forces grant to zero
//   reqVec      request vector, one bit per requester
//   enable      when low, no grant is issued
//   grant       one-hot grant (all zero when nothing granted)
//   grantIdx    binary index of the granted requester
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grantIdx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] candIdx;
  logic             found;

  // Search starts at ptr and wraps; first valid requester wins.
  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    candIdx  = '0;
    if (enable && !ctrl_reset) begin
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
        candIdx = IDX_W'((32'(ptr) + off) % NUM_REQ);
        if (!found && reqVec[candIdx]) begin
          found           = 1'b1;
          grant[candIdx]  = 1'b1;
          grantIdx        = candIdx;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port among
// NUM_REQ valid/ready requesters, one grant per cycle in round-robin order.
//   clock             rising-edge clock
//   ctrl_reset        asynchronous active-high reset
//   wb_stall          suppresses all grants in the current cycle
//   req_valid         per-requester write pending
//   req_reg           packed destination registers, slice i = requester i
//   req_data          packed write data, slice i = requester i
//   req_ready         one-hot grant (combinational)
//   ctrl_writeEnable  registered write enable (never set for r0)
//   ctrl_writeReg     registered write address
//   data_writeReg     registered write data
//   wb_conflict       registered: two or more requesters valid last cycle
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned DATA_W  = REG_DATA_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      wb_stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic                      wb_conflict
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grantIdx;
  logic               anyGrant;
  logic [ADDR_W-1:0]  selReg;
  logic [DATA_W-1:0]  selData;
  logic [7:0]         validExt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .reqVec     (req_valid),
    .enable     (!wb_stall),
    .grant      (grant),
    .grantIdx   (grantIdx)
  );

  assign req_ready = grant;
  assign anyGrant  = |grant;

  always_comb begin
    selReg  = '0;
    selData = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grantIdx == IDX_W'(i)) begin
        selReg  = req_reg[i*ADDR_W +: ADDR_W];
        selData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    validExt                 = '0;
    validExt[NUM_REQ-1:0]    = req_valid;
  end

  // r0 grants still load address/data; only the enable is filtered.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      wb_conflict      <= 1'b0;
    end else begin
      wb_conflict <= multiValid(validExt);
      if (anyGrant) begin
        ctrl_writeEnable <= (selReg != ADDR_W'(REG_ZERO));
        ctrl_writeReg    <= selReg;
        data_writeReg    <= selData;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        wb_stall = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [9:0]  req_reg = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        wb_conflict;

  regfile_wb_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .wb_stall         (wb_stall),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .wb_conflict      (wb_conflict)
  );

  always #5 clock = ~clock;

  int cycCount = 0;
  always @(posedge clock) cycCount <= cycCount + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          cyc;
    logic [36:0] val;
  } exp_t;

  exp_t readyQ[$];
  exp_t writeQ[$];
  exp_t confQ[$];

  // Downstream register file fed by the write port (no r0 masking here).
  logic [31:0] rf [32];
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clock) if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycCount);
    end
  endtask

  // Scoreboard monitor: checks whatever the DUT presents against queued expectations.
  always @(negedge clock) begin
    while (readyQ.size() > 0 && readyQ[0].cyc < cycCount) begin
      chk("ready_missed", 64'(readyQ[0].cyc), 64'(cycCount));
      void'(readyQ.pop_front());
    end
    if (readyQ.size() > 0 && readyQ[0].cyc == cycCount) begin
      chk("req_ready", 64'(req_ready), 64'(readyQ[0].val));
      void'(readyQ.pop_front());
    end

    while (confQ.size() > 0 && confQ[0].cyc < cycCount) begin
      chk("conf_missed", 64'(confQ[0].cyc), 64'(cycCount));
      void'(confQ.pop_front());
    end
    if (confQ.size() > 0 && confQ[0].cyc == cycCount) begin
      chk("wb_conflict", 64'(wb_conflict), 64'(confQ[0].val));
      void'(confQ.pop_front());
    end

    while (writeQ.size() > 0 && writeQ[0].cyc < cycCount) begin
      chk("write_missed", 64'(writeQ[0].cyc), 64'(cycCount));
      void'(writeQ.pop_front());
    end
    if (writeQ.size() > 0 && writeQ[0].cyc == cycCount) begin
      chk("wr_en", 64'(ctrl_writeEnable), 64'd1);
      chk("wr_reg_data", 64'({ctrl_writeReg, data_writeReg}), 64'(writeQ[0].val));
      void'(writeQ.pop_front());
    end else if (ctrl_writeEnable) begin
      chk("wr_unexpected", 64'(ctrl_writeEnable), 64'd0);
    end
  end

  // One cycle of stimulus with the hand-computed grant for that cycle.
  task automatic drive(input logic [1:0] v, input logic [4:0] ra, input logic [31:0] da,
                       input logic [4:0] rb, input logic [31:0] db, input logic st,
                       input logic [1:0] expRdy);
    @(posedge clock); #1;
    req_valid = v;
    req_reg   = {rb, ra};
    req_data  = {db, da};
    wb_stall  = st;
    readyQ.push_back('{cycCount, 37'(expRdy)});
    confQ.push_back('{cycCount + 1, 37'(v == 2'b11)});
    if (expRdy[0] && ra != 5'd0) writeQ.push_back('{cycCount + 1, {ra, da}});
    if (expRdy[1] && rb != 5'd0) writeQ.push_back('{cycCount + 1, {rb, db}});
  endtask

  task automatic idle(input int n);
    repeat (n) drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 2'b00);
  endtask

  task automatic rdCheck(input string name, input logic [4:0] r, input logic [31:0] exp);
    chk(name, 64'(rf[r]), 64'(exp));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_we",    64'(ctrl_writeEnable), 64'd0);
    chk("rst_reg",   64'(ctrl_writeReg),    64'd0);
    chk("rst_data",  64'(data_writeReg),    64'd0);
    chk("rst_conf",  64'(wb_conflict),      64'd0);
    chk("rst_ready", 64'(req_ready),        64'd0);
    ctrl_reset = 1'b0;

    // Single write, readback two cycles later (ptr -> 1)
    drive(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 2'b01);
    idle(2);
    rdCheck("rd_r7", 5'd7, 32'hDEADBEEF);

    // r0 filter: handshake completes, no write enable, fields load (ptr -> 0)
    drive(2'b10, 5'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 2'b10);
    idle(1);
    chk("r0_we",   64'(ctrl_writeEnable), 64'd0);
    chk("r0_reg",  64'(ctrl_writeReg),    64'd0);
    chk("r0_data", 64'(data_writeReg),    64'hFFFFFFFF);
    idle(1);
    rdCheck("rd_r0", 5'd0, 32'd0);

    // Contention: alternate grants, conflict from the second cycle
    drive(2'b11, 5'd3, 32'h000000A3, 5'd4, 32'h000000B4, 1'b0, 2'b01);
    drive(2'b11, 5'd3, 32'h000000A3, 5'd4, 32'h000000B4, 1'b0, 2'b10);
    drive(2'b11, 5'd3, 32'h000000A3, 5'd4, 32'h000000B4, 1'b0, 2'b01);
    drive(2'b11, 5'd3, 32'h000000A3, 5'd4, 32'h000000B4, 1'b0, 2'b10);
    idle(2);
    rdCheck("rd_r3", 5'd3, 32'h000000A3);
    rdCheck("rd_r4", 5'd4, 32'h000000B4);

    // Same register: later-granted value persists
    drive(2'b11, 5'd5, 32'h00001111, 5'd5, 32'h00002222, 1'b0, 2'b01);
    drive(2'b10, 5'd5, 32'h00001111, 5'd5, 32'h00002222, 1'b0, 2'b10);
    idle(2);
    rdCheck("rd_r5", 5'd5, 32'h00002222);

    // Stall: no grants, ptr held at 0, conflict still tracked
    repeat (3) drive(2'b11, 5'd6, 32'h00000066, 5'd8, 32'h00000088, 1'b1, 2'b00);
    drive(2'b11, 5'd6, 32'h00000066, 5'd8, 32'h00000088, 1'b0, 2'b01);

    // Reset mid-write: enable drops immediately, ptr returns to 0
    idle(1);
    @(negedge clock); #2;
    chk("pre_rst_we", 64'(ctrl_writeEnable), 64'd1);
    ctrl_reset = 1'b1;
    #1;
    chk("mid_rst_we",   64'(ctrl_writeEnable), 64'd0);
    chk("mid_rst_reg",  64'(ctrl_writeReg),    64'd0);
    chk("mid_rst_data", 64'(data_writeReg),    64'd0);
    req_valid = 2'b11;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    @(posedge clock); #1;
    req_valid = 2'b00;
    @(negedge clock);
    ctrl_reset = 1'b0;
    drive(2'b11, 5'd10, 32'h0000000A, 5'd11, 32'h0000000B, 1'b0, 2'b01);
    drive(2'b10, 5'd10, 32'h0000000A, 5'd11, 32'h0000000B, 1'b0, 2'b10);
    idle(2);
    rdCheck("rd_r10", 5'd10, 32'h0000000A);
    rdCheck("rd_r11", 5'd11, 32'h0000000B);

    idle(2);
    @(negedge clock); #1;
    chk("write_queue_drained", 64'(writeQ.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
